// File: rtl/demux_frame_sequencer.sv
// Frame sequencer ahead of a 1:4 demux: accepts serial frames over valid/ready, picks a channel
// (addressed or round-robin) and drives registered s1/s0/d, with per-channel frame counters.
module demux_frame_sequencer #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_sop,
    input  logic               in_bit,
    input  logic [1:0]         in_dest,
    input  logic               rr_en,
    output logic               s1,
    output logic               s0,
    output logic               d,
    output logic               frame_done,
    output logic               err,
    output logic [4*CNT_W-1:0] frame_cnt
);

    localparam int unsigned     GapW      = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [7:0]      LastIdx   = 8'(DATA_BITS - 1);
    localparam logic [GapW-1:0] GapLast   = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam bit              SingleBit = (DATA_BITS == 1);

    typedef enum logic [1:0] {StIdle, StData, StGap} state_t;

    localparam state_t EndState = (GAP_CYCLES == 0) ? StIdle : StGap;

    state_t            state_q;
    logic              ready_en_q;
    logic [1:0]        ch_q;
    logic              rr_frame_q;
    logic [1:0]        rr_ptr_q;
    logic [7:0]        bit_cnt_q;
    logic [GapW-1:0]   gap_cnt_q;
    logic              d_q;
    logic              done_q;
    logic              err_q;
    logic [CNT_W-1:0]  cnt_q [4];

    logic       xfer;
    logic       in_idle;
    logic [1:0] sop_ch;
    logic [1:0] cur_ch;
    logic       cur_rr;
    logic       complete;

    assign in_ready = ready_en_q & (state_q != StGap);
    assign xfer     = in_valid & in_ready;
    assign in_idle  = (state_q == StIdle);
    assign sop_ch   = rr_en ? rr_ptr_q : in_dest;
    // A single-bit frame completes on its sop beat, so channel/mode come straight from the inputs.
    assign cur_ch   = in_idle ? sop_ch : ch_q;
    assign cur_rr   = in_idle ? rr_en : rr_frame_q;

    always_comb begin
        complete = 1'b0;
        if (xfer) begin
            if (in_idle) begin
                complete = in_sop & SingleBit;
            end else if (state_q == StData) begin
                complete = ~in_sop & (bit_cnt_q == LastIdx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_en_q <= 1'b0;
            ch_q       <= 2'd0;
            rr_frame_q <= 1'b0;
            rr_ptr_q   <= 2'd0;
            bit_cnt_q  <= 8'd0;
            gap_cnt_q  <= '0;
            d_q        <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            ready_en_q <= 1'b1;
            d_q        <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;

            if (complete) begin
                done_q <= 1'b1;
                if (cnt_q[cur_ch] != CntMax) begin
                    cnt_q[cur_ch] <= cnt_q[cur_ch] + CNT_W'(1);
                end
                if (cur_rr) begin
                    rr_ptr_q <= rr_ptr_q + 2'd1;
                end
            end

            case (state_q)
                StIdle: begin
                    if (xfer && in_sop) begin
                        ch_q       <= sop_ch;
                        rr_frame_q <= rr_en;
                        d_q        <= in_bit;
                        if (SingleBit) begin
                            state_q   <= EndState;
                            bit_cnt_q <= 8'd0;
                            gap_cnt_q <= '0;
                        end else begin
                            state_q   <= StData;
                            bit_cnt_q <= 8'd1;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
                        if (in_sop) begin
                            // Unexpected sop aborts the frame; the beat itself is discarded.
                            err_q     <= 1'b1;
                            state_q   <= EndState;
                            bit_cnt_q <= 8'd0;
                            gap_cnt_q <= '0;
                        end else begin
                            d_q <= in_bit;
                            if (bit_cnt_q == LastIdx) begin
                                state_q   <= EndState;
                                bit_cnt_q <= 8'd0;
                                gap_cnt_q <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 8'd1;
                            end
                        end
                    end
                end
                StGap: begin
                    if (gap_cnt_q == GapLast) begin
                        state_q <= StIdle;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GapW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign s1         = ch_q[1];
    assign s0         = ch_q[0];
    assign d          = d_q;
    assign frame_done = done_q;
    assign err        = err_q;

    always_comb begin
        frame_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            frame_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule
